// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default parameters for the instruction/data memory port arbiter.
// Contents: arb_state_t (IDLE, WAIT), arb_owner_t (OWN_IF, OWN_DM),
// default widths, memory latency and fetch starvation limit.
package mem_port_arbiter_pkg;

    localparam int unsigned DEF_AW         = 9;
    localparam int unsigned DEF_DW         = 64;
    localparam int unsigned DEF_MEM_LAT    = 1;
    localparam int unsigned DEF_STARVE_MAX = 3;

    // Wide enough for any legal MEM_LAT-1 (MEM_LAT is 1..15)
    localparam int unsigned WAIT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Fixed-priority pick between fetch and data requesters.
// Data wins a conflict unless fetch has hit its starvation limit.
// Ports:
//   if_req_i, dm_req_i  : requests from fetch / data stage
//   starve_hit_i        : fetch has lost STARVE_MAX arbitrations in a row
//   winner_o            : requester that wins this cycle (valid when grant_any_o)
//   grant_any_o         : at least one request is present
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic       if_req_i,
    input  logic       dm_req_i,
    input  logic       starve_hit_i,
    output arb_owner_t winner_o,
    output logic       grant_any_o
);

    assign grant_any_o = if_req_i | dm_req_i;
    assign winner_o    = (dm_req_i && !(if_req_i && starve_hit_i)) ? OWN_DM : OWN_IF;

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch reads and data reads/writes onto one single-ported memory.
// One access is in flight at a time; the memory latency is sequenced by a
// wait counter, and a starvation counter forces fetch through after
// STARVE_MAX consecutive lost conflicts.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   if_*                : fetch req/addr in, gnt (comb) / valid / rdata out
//   dm_*                : data req/we/addr/wdata in, gnt (comb) / valid / rdata out
//   mem_*               : memory strobe, write enable, address, write data (comb), read data in
//   fetch_stall         : fetch requesting but not granted this cycle (comb)
// Optional: define ARB_PERF_CNT_EN to add perf_conflict, perf_if_stall and
// perf_starve_force 32-bit wrapping event counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW         = DEF_AW,
    parameter int unsigned DW         = DEF_DW,
    parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_valid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          fetch_stall
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]   perf_conflict,
    output logic [31:0]   perf_if_stall,
    output logic [31:0]   perf_starve_force
`endif
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              if_valid_q, if_valid_d;
    logic              dm_valid_q, dm_valid_d;
    logic [DW-1:0]     if_rdata_q, if_rdata_d;
    logic [DW-1:0]     dm_rdata_q, dm_rdata_d;

    arb_owner_t        winner;
    logic              grant_any;
    logic              arb_en;
    logic              starve_hit;
    logic              grant;
    logic              conflict;

    // Arbitration only while out of reset and idle, so reset forces every grant low
    assign arb_en     = rst && (state_q == IDLE);
    assign starve_hit = (starve_q == SW'(STARVE_MAX));
    assign conflict   = arb_en && if_req && dm_req;

    mem_arb_pick u_pick (
        .if_req_i     (if_req),
        .dm_req_i     (dm_req),
        .starve_hit_i (starve_hit),
        .winner_o     (winner),
        .grant_any_o  (grant_any)
    );

    // Grant and memory command, same cycle as the request
    assign grant       = arb_en && grant_any;
    assign if_gnt      = grant && (winner == OWN_IF);
    assign dm_gnt      = grant && (winner == OWN_DM);
    assign mem_en      = grant;
    assign mem_we      = dm_gnt && dm_we;
    assign mem_addr    = dm_gnt ? dm_addr  : (if_gnt ? if_addr : '0);
    assign mem_wdata   = dm_gnt ? dm_wdata : '0;
    assign fetch_stall = rst && if_req && !if_gnt;

    assign if_valid = if_valid_q;
    assign dm_valid = dm_valid_q;
    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;

    // Next-state: arbitration in IDLE, latency countdown and response capture in WAIT
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wr_d       = wr_q;
        wait_d     = wait_q;
        starve_d   = starve_q;
        if_valid_d = 1'b0;
        dm_valid_d = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        case (state_q)
            IDLE: begin
                // dm can only win a conflict below the limit, so this saturates
                if (conflict && dm_gnt) begin
                    starve_d = starve_q + SW'(1);
                end
                if (if_gnt) begin
                    starve_d = '0;
                end
                if (grant) begin
                    owner_d = winner;
                    wr_d    = dm_gnt && dm_we;
                    wait_d  = WAIT_W'(MEM_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - WAIT_W'(1);
                end else begin
                    state_d = IDLE;
                    if (owner_q == OWN_IF) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else begin
                        dm_valid_d = 1'b1;
                        dm_rdata_d = wr_q ? '0 : mem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            wr_q       <= 1'b0;
            wait_q     <= '0;
            starve_q   <= '0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wr_q       <= wr_d;
            wait_q     <= wait_d;
            starve_q   <= starve_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_conflict_q;
    logic [31:0] perf_if_stall_q;
    logic [31:0] perf_starve_force_q;

    // Event counters, free-running and wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_conflict_q     <= '0;
            perf_if_stall_q     <= '0;
            perf_starve_force_q <= '0;
        end else begin
            perf_conflict_q     <= perf_conflict_q + 32'(conflict);
            perf_if_stall_q     <= perf_if_stall_q + 32'(fetch_stall);
            perf_starve_force_q <= perf_starve_force_q + 32'(conflict && starve_hit);
        end
    end

    assign perf_conflict     = perf_conflict_q;
    assign perf_if_stall     = perf_if_stall_q;
    assign perf_starve_force = perf_starve_force_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Instance A: MEM_LAT=1, STARVE_MAX=3. Instance B: MEM_LAT=3, STARVE_MAX=1.
// Each instance has a small memory model; expected responses are queued when
// a grant is issued and compared when the valid pulse appears.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    typedef struct {
        logic        dm;
        logic [63:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t a_q[$];
    exp_t b_q[$];
    exp_t ea;
    exp_t eb;

    // Instance A signals
    logic        a_if_req = 1'b0;
    logic [8:0]  a_if_addr = '0;
    logic        a_if_gnt, a_if_valid;
    logic [63:0] a_if_rdata;
    logic        a_dm_req = 1'b0;
    logic        a_dm_we = 1'b0;
    logic [8:0]  a_dm_addr = '0;
    logic [63:0] a_dm_wdata = '0;
    logic        a_dm_gnt, a_dm_valid;
    logic [63:0] a_dm_rdata;
    logic        a_mem_en, a_mem_we;
    logic [8:0]  a_mem_addr;
    logic [63:0] a_mem_wdata, a_mem_rdata;
    logic        a_fetch_stall;

    // Instance B signals
    logic        b_if_req = 1'b0;
    logic [8:0]  b_if_addr = '0;
    logic        b_if_gnt, b_if_valid;
    logic [63:0] b_if_rdata;
    logic        b_dm_req = 1'b0;
    logic        b_dm_we = 1'b0;
    logic [8:0]  b_dm_addr = '0;
    logic [63:0] b_dm_wdata = '0;
    logic        b_dm_gnt, b_dm_valid;
    logic [63:0] b_dm_rdata;
    logic        b_mem_en, b_mem_we;
    logic [8:0]  b_mem_addr;
    logic [63:0] b_mem_wdata, b_mem_rdata;
    logic        b_fetch_stall;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] a_perf_conflict, a_perf_if_stall, a_perf_starve_force;
    logic [31:0] b_perf_conflict, b_perf_if_stall, b_perf_starve_force;
`endif

    mem_port_arbiter #(.AW(9), .DW(64), .MEM_LAT(1), .STARVE_MAX(3)) u_dut_a (
        .clk(clk), .rst(rst),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
        .if_valid(a_if_valid), .if_rdata(a_if_rdata),
        .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
        .dm_gnt(a_dm_gnt), .dm_valid(a_dm_valid), .dm_rdata(a_dm_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .fetch_stall(a_fetch_stall)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_conflict(a_perf_conflict), .perf_if_stall(a_perf_if_stall),
        .perf_starve_force(a_perf_starve_force)
`endif
    );

    mem_port_arbiter #(.AW(9), .DW(64), .MEM_LAT(3), .STARVE_MAX(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_valid(b_if_valid), .if_rdata(b_if_rdata),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_gnt(b_dm_gnt), .dm_valid(b_dm_valid), .dm_rdata(b_dm_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .fetch_stall(b_fetch_stall)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_conflict(b_perf_conflict), .perf_if_stall(b_perf_if_stall),
        .perf_starve_force(b_perf_starve_force)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pat(input logic [8:0] a);
        return {32'hA5A5_0000, 23'd0, a};
    endfunction

    // Memory models: read data appears the cycle after mem_en and is held;
    // a write leaves all-ones on the read bus so a write ack must mask it
    logic [63:0] a_mem [0:511];
    logic [63:0] b_mem [0:511];
    logic [63:0] a_mrd = '0;
    logic [63:0] b_mrd = '0;

    initial begin
        for (int i = 0; i < 512; i++) begin
            a_mem[i] = pat(9'(i));
            b_mem[i] = pat(9'(i));
        end
        a_mem[4] = 64'hDEADBEEF00000001;
    end

    always @(posedge clk) begin
        if (a_mem_en) begin
            if (a_mem_we) begin
                a_mem[a_mem_addr] <= a_mem_wdata;
                a_mrd <= '1;
            end else begin
                a_mrd <= a_mem[a_mem_addr];
            end
        end
        if (b_mem_en) begin
            if (b_mem_we) begin
                b_mem[b_mem_addr] <= b_mem_wdata;
                b_mrd <= '1;
            end else begin
                b_mrd <= b_mem[b_mem_addr];
            end
        end
    end

    assign a_mem_rdata = a_mrd;
    assign b_mem_rdata = b_mrd;

    // Response scoreboards
    always @(negedge clk) begin
        if (a_if_valid === 1'b1 || a_dm_valid === 1'b1) begin
            tests_run++;
            if (a_q.size() == 0) begin
                tests_failed++;
                $display("FAIL a_unexpected_resp: if_valid=%b dm_valid=%b at cycle %0d, required no response",
                         a_if_valid, a_dm_valid, cyc);
            end else begin
                ea = a_q.pop_front();
                if ({a_dm_valid, a_if_valid} !== {ea.dm, ~ea.dm} ||
                    (a_dm_valid ? a_dm_rdata : a_if_rdata) !== ea.data || cyc != ea.due) begin
                    tests_failed++;
                    $display("FAIL a_resp: dm_valid=%b if_valid=%b data=%h cycle=%0d, required dm=%b data=%h cycle=%0d",
                             a_dm_valid, a_if_valid, (a_dm_valid ? a_dm_rdata : a_if_rdata), cyc,
                             ea.dm, ea.data, ea.due);
                end
            end
        end
        if (b_if_valid === 1'b1 || b_dm_valid === 1'b1) begin
            tests_run++;
            if (b_q.size() == 0) begin
                tests_failed++;
                $display("FAIL b_unexpected_resp: if_valid=%b dm_valid=%b at cycle %0d, required no response",
                         b_if_valid, b_dm_valid, cyc);
            end else begin
                eb = b_q.pop_front();
                if ({b_dm_valid, b_if_valid} !== {eb.dm, ~eb.dm} ||
                    (b_dm_valid ? b_dm_rdata : b_if_rdata) !== eb.data || cyc != eb.due) begin
                    tests_failed++;
                    $display("FAIL b_resp: dm_valid=%b if_valid=%b data=%h cycle=%0d, required dm=%b data=%h cycle=%0d",
                             b_dm_valid, b_if_valid, (b_dm_valid ? b_dm_rdata : b_if_rdata), cyc,
                             eb.dm, eb.data, eb.due);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_if_req = 1'b1; a_if_addr = 9'h001; a_dm_req = 1'b1; a_dm_we = 1'b1;
        a_dm_addr = 9'h002; a_dm_wdata = 64'h1;
        b_if_req = 1'b1; b_dm_req = 1'b1; b_dm_addr = 9'h003;
        @(negedge clk);
        tests_run++;
        if ({a_if_gnt, a_dm_gnt, a_mem_en, a_mem_we, a_fetch_stall, a_if_valid, a_dm_valid} !== 7'b0 ||
            a_mem_addr !== 9'h0 || a_mem_wdata !== 64'h0 || a_if_rdata !== 64'h0 || a_dm_rdata !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs_a: ctrl=%b addr=%h wdata=%h ifr=%h dmr=%h, required all zero",
                     {a_if_gnt, a_dm_gnt, a_mem_en, a_mem_we, a_fetch_stall, a_if_valid, a_dm_valid},
                     a_mem_addr, a_mem_wdata, a_if_rdata, a_dm_rdata);
        end
        tests_run++;
        if ({b_if_gnt, b_dm_gnt, b_mem_en, b_mem_we, b_fetch_stall, b_if_valid, b_dm_valid} !== 7'b0 ||
            b_mem_addr !== 9'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs_b: ctrl=%b addr=%h, required all zero",
                     {b_if_gnt, b_dm_gnt, b_mem_en, b_mem_we, b_fetch_stall, b_if_valid, b_dm_valid}, b_mem_addr);
        end
        a_if_req = 1'b0; a_dm_req = 1'b0; a_dm_we = 1'b0; a_dm_wdata = 64'h0;
        b_if_req = 1'b0; b_dm_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        tests_run++;
        if ({a_if_gnt, a_dm_gnt, a_mem_en, a_fetch_stall} !== 4'b0) begin
            tests_failed++;
            $display("FAIL idle_no_req: gnt_if/gnt_dm/mem_en/stall=%b, required 0000",
                     {a_if_gnt, a_dm_gnt, a_mem_en, a_fetch_stall});
        end
        step();
    endtask

    task automatic test_if_read();
        int t;
        a_if_addr = 9'h004; a_if_req = 1'b1;
        @(negedge clk);
        t = cyc;
        tests_run++;
        if (a_if_gnt !== 1'b1 || a_dm_gnt !== 1'b0 || a_mem_en !== 1'b1 || a_mem_we !== 1'b0 ||
            a_mem_addr !== 9'h004 || a_mem_wdata !== 64'h0 || a_fetch_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL if_read_grant: if_gnt=%b dm_gnt=%b mem_en=%b we=%b addr=%h stall=%b, required 1 0 1 0 004 0",
                     a_if_gnt, a_dm_gnt, a_mem_en, a_mem_we, a_mem_addr, a_fetch_stall);
        end
        a_q.push_back('{1'b0, 64'hDEADBEEF00000001, t + 2});
        step();
        a_if_req = 1'b0;
        for (int c = 0; c < 20 && a_q.size() != 0; c++) step();
        tests_run++;
        if (a_q.size() != 0) begin
            tests_failed++;
            $display("FAIL if_read_drain: %0d outstanding, required 0", a_q.size());
            a_q.delete();
        end
    endtask

    task automatic test_conflict();
        int t;
        a_if_addr = 9'h008; a_if_req = 1'b1;
        a_dm_addr = 9'h010; a_dm_we = 1'b0; a_dm_req = 1'b1;
        @(negedge clk);
        t = cyc;
        tests_run++;
        if (a_dm_gnt !== 1'b1 || a_if_gnt !== 1'b0 || a_fetch_stall !== 1'b1 || a_mem_addr !== 9'h010) begin
            tests_failed++;
            $display("FAIL conflict_dm_first: dm_gnt=%b if_gnt=%b stall=%b addr=%h, required 1 0 1 010",
                     a_dm_gnt, a_if_gnt, a_fetch_stall, a_mem_addr);
        end
        a_q.push_back('{1'b1, pat(9'h010), t + 2});
        step();
        a_dm_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (a_if_gnt !== 1'b0 || a_mem_en !== 1'b0 || a_fetch_stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL conflict_wait: if_gnt=%b mem_en=%b stall=%b, required 0 0 1",
                     a_if_gnt, a_mem_en, a_fetch_stall);
        end
        step();
        @(negedge clk);
        tests_run++;
        if (a_if_gnt !== 1'b1 || a_mem_addr !== 9'h008 || a_fetch_stall !== 1'b0 || cyc != t + 2 ||
            a_if_rdata !== 64'hDEADBEEF00000001) begin
            tests_failed++;
            $display("FAIL conflict_if_next: if_gnt=%b addr=%h stall=%b cycle=%0d if_rdata=%h, required 1 008 0 %0d deadbeef00000001",
                     a_if_gnt, a_mem_addr, a_fetch_stall, cyc, a_if_rdata, t + 2);
        end
        a_q.push_back('{1'b0, pat(9'h008), t + 4});
        step();
        a_if_req = 1'b0;
        for (int c = 0; c < 20 && a_q.size() != 0; c++) step();
        tests_run++;
        if (a_q.size() != 0) begin
            tests_failed++;
            $display("FAIL conflict_drain: %0d outstanding, required 0", a_q.size());
            a_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        int   last;
        logic got;
        logic exp_dm;
        last = 0;
        a_if_addr = 9'h00C; a_if_req = 1'b1;
        a_dm_addr = 9'h020; a_dm_we = 1'b1; a_dm_wdata = 64'h55; a_dm_req = 1'b1;
        for (int g = 0; g < 5; g++) begin
            got = 1'b0;
            for (int c = 0; c < 6 && !got; c++) begin
                @(negedge clk);
                if (a_if_gnt === 1'b1 || a_dm_gnt === 1'b1) got = 1'b1;
                else step();
            end
            exp_dm = (g != 3);
            tests_run++;
            if (!got || a_dm_gnt !== exp_dm || a_if_gnt !== !exp_dm || a_mem_we !== exp_dm ||
                a_mem_wdata !== (exp_dm ? 64'h55 : 64'h0) || (g > 0 && cyc - last != 2)) begin
                tests_failed++;
                $display("FAIL starve_grant%0d: got=%b dm_gnt=%b if_gnt=%b we=%b wdata=%h gap=%0d, required dm_gnt=%b gap=2",
                         g, got, a_dm_gnt, a_if_gnt, a_mem_we, a_mem_wdata, cyc - last, exp_dm);
            end
            if (got) begin
                if (exp_dm) a_q.push_back('{1'b1, 64'h0, cyc + 2});
                else        a_q.push_back('{1'b0, pat(9'h00C), cyc + 2});
                last = cyc;
            end
            step();
        end
        a_if_req = 1'b0; a_dm_req = 1'b0; a_dm_we = 1'b0;
        for (int c = 0; c < 20 && a_q.size() != 0; c++) step();
        tests_run++;
        if (a_q.size() != 0) begin
            tests_failed++;
            $display("FAIL starve_drain: %0d outstanding, required 0", a_q.size());
            a_q.delete();
        end
    endtask

    task automatic test_write_readback();
        int t;
        a_dm_addr = 9'h020; a_dm_we = 1'b0; a_dm_req = 1'b1;
        @(negedge clk);
        t = cyc;
        tests_run++;
        if (a_dm_gnt !== 1'b1 || a_mem_we !== 1'b0 || a_mem_addr !== 9'h020) begin
            tests_failed++;
            $display("FAIL readback_grant: dm_gnt=%b we=%b addr=%h, required 1 0 020",
                     a_dm_gnt, a_mem_we, a_mem_addr);
        end
        a_q.push_back('{1'b1, 64'h55, t + 2});
        step();
        a_dm_req = 1'b0;
        for (int c = 0; c < 20 && a_q.size() != 0; c++) step();
        tests_run++;
        if (a_q.size() != 0) begin
            tests_failed++;
            $display("FAIL readback_drain: %0d outstanding, required 0", a_q.size());
            a_q.delete();
        end
    endtask

    task automatic test_lat3();
        int t;
        b_if_addr = 9'h034; b_if_req = 1'b1;
        b_dm_addr = 9'h030; b_dm_we = 1'b0; b_dm_req = 1'b1;
        @(negedge clk);
        t = cyc;
        tests_run++;
        if (b_dm_gnt !== 1'b1 || b_if_gnt !== 1'b0 || b_mem_addr !== 9'h030) begin
            tests_failed++;
            $display("FAIL lat3_grant: dm_gnt=%b if_gnt=%b addr=%h, required 1 0 030",
                     b_dm_gnt, b_if_gnt, b_mem_addr);
        end
        b_q.push_back('{1'b1, pat(9'h030), t + 4});
        step();
        b_dm_req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (b_if_gnt !== 1'b0 || b_dm_gnt !== 1'b0 || b_mem_en !== 1'b0 || b_fetch_stall !== 1'b1) begin
                tests_failed++;
                $display("FAIL lat3_wait_t%0d: if_gnt=%b dm_gnt=%b mem_en=%b stall=%b, required 0 0 0 1",
                         c, b_if_gnt, b_dm_gnt, b_mem_en, b_fetch_stall);
            end
            step();
        end
        @(negedge clk);
        tests_run++;
        if (b_if_gnt !== 1'b1 || b_mem_addr !== 9'h034 || cyc != t + 4) begin
            tests_failed++;
            $display("FAIL lat3_if_grant: if_gnt=%b addr=%h cycle=%0d, required 1 034 %0d",
                     b_if_gnt, b_mem_addr, cyc, t + 4);
        end
        b_q.push_back('{1'b0, pat(9'h034), t + 8});
        step();
        b_if_req = 1'b0;
        for (int c = 0; c < 20 && b_q.size() != 0; c++) step();
        tests_run++;
        if (b_q.size() != 0) begin
            tests_failed++;
            $display("FAIL lat3_drain: %0d outstanding, required 0", b_q.size());
            b_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int t;
        a_if_addr = 9'h004; a_if_req = 1'b1;
        @(negedge clk);
        tests_run++;
        if (a_if_gnt !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_grant: if_gnt=%b, required 1", a_if_gnt);
        end
        step();
        rst = 1'b0;
        #1;
        tests_run++;
        if ({a_if_gnt, a_dm_gnt, a_mem_en, a_mem_we, a_fetch_stall, a_if_valid, a_dm_valid} !== 7'b0 ||
            a_mem_addr !== 9'h0 || a_if_rdata !== 64'h0 || a_dm_rdata !== 64'h0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: ctrl=%b addr=%h ifr=%h dmr=%h, required all zero",
                     {a_if_gnt, a_dm_gnt, a_mem_en, a_mem_we, a_fetch_stall, a_if_valid, a_dm_valid},
                     a_mem_addr, a_if_rdata, a_dm_rdata);
        end
        a_if_req = 1'b0;
        step();
        step();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests_run++;
            if (a_if_valid !== 1'b0 || a_dm_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL rstmid_no_valid%0d: if_valid=%b dm_valid=%b, required 0 0",
                         c, a_if_valid, a_dm_valid);
            end
            step();
        end
        a_if_addr = 9'h008; a_if_req = 1'b1;
        @(negedge clk);
        t = cyc;
        tests_run++;
        if (a_if_gnt !== 1'b1 || a_mem_en !== 1'b1 || a_mem_addr !== 9'h008) begin
            tests_failed++;
            $display("FAIL rstmid_regrant: if_gnt=%b mem_en=%b addr=%h, required 1 1 008",
                     a_if_gnt, a_mem_en, a_mem_addr);
        end
        a_q.push_back('{1'b0, pat(9'h008), t + 2});
        step();
        a_if_req = 1'b0;
        for (int c = 0; c < 20 && a_q.size() != 0; c++) step();
        tests_run++;
        if (a_q.size() != 0) begin
            tests_failed++;
            $display("FAIL rstmid_drain: %0d outstanding, required 0", a_q.size());
            a_q.delete();
        end
    endtask

`ifdef ARB_PERF_CNT_EN
    task automatic test_perf();
        logic got;
        logic exp_dm;
        tests_run++;
        if (b_perf_conflict !== 32'd0 || b_perf_if_stall !== 32'd0 || b_perf_starve_force !== 32'd0) begin
            tests_failed++;
            $display("FAIL perf_after_reset: conflict=%0d stall=%0d force=%0d, required 0 0 0",
                     b_perf_conflict, b_perf_if_stall, b_perf_starve_force);
        end
        b_if_addr = 9'h040; b_if_req = 1'b1;
        b_dm_addr = 9'h044; b_dm_we = 1'b0; b_dm_req = 1'b1;
        for (int g = 0; g < 5; g++) begin
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                @(negedge clk);
                if (b_if_gnt === 1'b1 || b_dm_gnt === 1'b1) got = 1'b1;
                else step();
            end
            exp_dm = (g % 2 == 0);
            tests_run++;
            if (!got || b_dm_gnt !== exp_dm || b_if_gnt !== !exp_dm) begin
                tests_failed++;
                $display("FAIL perf_grant%0d: got=%b dm_gnt=%b if_gnt=%b, required dm_gnt=%b",
                         g, got, b_dm_gnt, b_if_gnt, exp_dm);
            end
            if (got) begin
                if (exp_dm) b_q.push_back('{1'b1, pat(9'h044), cyc + 4});
                else        b_q.push_back('{1'b0, pat(9'h040), cyc + 4});
            end
            step();
        end
        b_if_req = 1'b0; b_dm_req = 1'b0;
        for (int c = 0; c < 30 && b_q.size() != 0; c++) step();
        tests_run++;
        if (b_q.size() != 0) begin
            tests_failed++;
            $display("FAIL perf_drain: %0d outstanding, required 0", b_q.size());
            b_q.delete();
        end
        tests_run++;
        if (b_perf_conflict !== 32'd5 || b_perf_if_stall !== 32'd15 || b_perf_starve_force !== 32'd2) begin
            tests_failed++;
            $display("FAIL perf_counts: conflict=%0d stall=%0d force=%0d, required 5 15 2",
                     b_perf_conflict, b_perf_if_stall, b_perf_starve_force);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_if_read();
        test_conflict();
        test_back_to_back();
        test_write_readback();
        test_lat3();
        test_reset_mid();
`ifdef ARB_PERF_CNT_EN
        test_perf();
`endif
        step();
        step();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
